rxdata: RTL



---
 rtl/rxdata.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/rxdata.sv
// ASCII hex line parser: "0x" + 1..8 hex digits + optional CR + LF -> 32-bit word.
// state     | meaning
// IDLE      | between lines, waiting for leading '0'
// ZERO      | '0' seen, expecting 'x'
// HEX       | collecting hex digits
// WAIT_LF   | CR seen, expecting LF
// DISCARD   | malformed line, skipping to LF
module rxdata #(
   parameter bit OPT_UPPER      = 1'b1,
   parameter bit OPT_REQUIRE_CR = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_rx_stb,
   input  logic [7:0]  i_rx_data,
   output logic        o_stb,
   output logic [31:0] o_data,
   output logic        o_err,
   output logic        o_busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_ZERO, S_HEX, S_WAIT_LF, S_DISCARD
   } state_t;

   localparam logic [7:0] CH_LF    = 8'h0a;
   localparam logic [7:0] CH_CR    = 8'h0d;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_ZERO  = 8'h30;
   localparam logic [7:0] CH_NINE  = 8'h39;
   localparam logic [7:0] CH_UA    = 8'h41;
   localparam logic [7:0] CH_UF    = 8'h46;
   localparam logic [7:0] CH_UX    = 8'h58;
   localparam logic [7:0] CH_LA    = 8'h61;
   localparam logic [7:0] CH_LF_HEX = 8'h66;
   localparam logic [7:0] CH_LX    = 8'h78;

   state_t      state, state_nxt;
   logic [31:0] acc, acc_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] data_nxt;
   logic        stb_nxt, err_nxt;
   logic        is_hex, is_lf, is_cr, is_x;
   logic [3:0]  nibble;
   logic        bad, emit;

   // Letters 'a'-'f' and 'A'-'F' have low nibble 1..6, so +9 maps them to 10..15.
   always_comb begin
      is_hex = 1'b0;
      nibble = 4'd0;
      if (i_rx_data >= CH_ZERO && i_rx_data <= CH_NINE) begin
         is_hex = 1'b1;
         nibble = i_rx_data[3:0];
      end else if ((i_rx_data >= CH_LA && i_rx_data <= CH_LF_HEX) ||
                   (OPT_UPPER && i_rx_data >= CH_UA && i_rx_data <= CH_UF)) begin
         is_hex = 1'b1;
         nibble = i_rx_data[3:0] + 4'd9;
      end
   end

   assign is_lf = (i_rx_data == CH_LF);
   assign is_cr = (i_rx_data == CH_CR);
   assign is_x  = (i_rx_data == CH_LX) || (OPT_UPPER && i_rx_data == CH_UX);

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      data_nxt  = o_data;
      stb_nxt   = 1'b0;
      err_nxt   = 1'b0;
      bad       = 1'b0;
      emit      = 1'b0;
      if (i_rx_stb) begin
         case (state)
            S_IDLE: begin
               if (i_rx_data == CH_ZERO)
                  state_nxt = S_ZERO;
               else if (!(i_rx_data == CH_SPACE || is_cr || is_lf))
                  bad = 1'b1;
            end
            S_ZERO: begin
               if (is_x) begin
                  state_nxt = S_HEX;
                  acc_nxt   = 32'd0;
                  cnt_nxt   = 4'd0;
               end else begin
                  bad = 1'b1;
               end
            end
            S_HEX: begin
               if (is_hex) begin
                  if (cnt == 4'd8) begin
                     bad = 1'b1;
                  end else begin
                     acc_nxt = {acc[27:0], nibble};
                     cnt_nxt = cnt + 4'd1;
                  end
               end else if (is_cr) begin
                  if (cnt != 4'd0) state_nxt = S_WAIT_LF;
                  else             bad = 1'b1;
               end else if (is_lf) begin
                  if (cnt != 4'd0 && !OPT_REQUIRE_CR) emit = 1'b1;
                  else                                bad  = 1'b1;
               end else begin
                  bad = 1'b1;
               end
            end
            S_WAIT_LF: begin
               if (is_lf) emit = 1'b1;
               else       bad  = 1'b1;
            end
            S_DISCARD: begin
               if (is_lf) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase

         if (emit) begin
            stb_nxt   = 1'b1;
            data_nxt  = acc;
            state_nxt = S_IDLE;
            acc_nxt   = 32'd0;
            cnt_nxt   = 4'd0;
         end
         // An LF that is itself malformed already ends the line, so no discard.
         if (bad) begin
            err_nxt   = 1'b1;
            state_nxt = is_lf ? S_IDLE : S_DISCARD;
            acc_nxt   = 32'd0;
            cnt_nxt   = 4'd0;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state  <= S_IDLE;
         acc    <= 32'd0;
         cnt    <= 4'd0;
         o_data <= 32'd0;
         o_stb  <= 1'b0;
         o_err  <= 1'b0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         o_data <= data_nxt;
         o_stb  <= stb_nxt;
         o_err  <= err_nxt;
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule
